keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 155 +++++++++++++++
 tb/tb_keypad_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one active-low column at a time,
// samples the synchronized rows, debounces a single key and reports its
// one-hot {row, column} code with a one-cycle press strobe.
module keypad_scanner #(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [7:0] keypad_val,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAXP = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   deb_q, deb_d;
  logic [3:0]      rowcode_q, rowcode_d;
  logic [3:0]      colcode_q, colcode_d;
  logic [7:0]      val_q, val_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic [3:0]      sync1_q, rs_q;

  // True when exactly one row line is pulled low.
  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] a;
    a = ~v;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  assign col_n      = ~(4'b0001 << idx_q);
  assign keypad_val = val_q;
  assign key_valid  = valid_q;
  assign key_held   = held_q;

  // Two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      rs_q    <= 4'b1111;
    end else begin
      sync1_q <= row_n;
      rs_q    <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SCAN;
      idx_q     <= 2'd0;
      dwell_q   <= '0;
      deb_q     <= '0;
      rowcode_q <= 4'd0;
      colcode_q <= 4'd0;
      val_q     <= 8'h00;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      rowcode_q <= rowcode_d;
      colcode_q <= colcode_d;
      val_q     <= val_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    deb_d     = deb_q;
    rowcode_d = rowcode_q;
    colcode_d = colcode_q;
    val_d     = val_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    case (state_q)
      SCAN: begin
        // Rows are only trusted on the last dwell cycle, after the
        // synchronizer has caught up with the column change.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low(rs_q)) begin
            rowcode_d = ~rs_q;
            colcode_d = 4'b1000 >> idx_q;
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (~rs_q == rowcode_q) begin
          if (deb_q == DEB_LAST) begin
            val_d   = {rowcode_q, colcode_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
          end else begin
            deb_d = deb_q + CNT_ONE;
          end
        end else begin
          state_d = SCAN;
          idx_d   = idx_q + 2'd1;
          dwell_d = '0;
        end
      end
      HELD: begin
        // Extra rows on the frozen column are ignored; only a full
        // release starts the release debounce.
        if (rs_q == 4'b1111) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rs_q == 4'b1111) begin
          if (deb_q == DEB_LAST) begin
            held_d  = 1'b0;
            state_d = SCAN;
            idx_d   = idx_q + 2'd1;
            dwell_d = '0;
          end else begin
            deb_d = deb_q + CNT_ONE;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scenarios plus
// random key activity, checked each cycle against a sequential
// behavioural model of the scanner.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] keypad_val;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c pressed

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
    .keypad_val(keypad_val), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] m_idx  = 2'd0;
  logic [7:0] m_val  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;
  logic [3:0] h1 = 4'hF, h2 = 4'hF;
  bit         rflag = 1'b0;
  bit         m_in_deb = 1'b0;

  // One clock edge: returns the row value the scanner acts on at this edge
  // (pin value from two edges back) and applies reset if it was asserted.
  task automatic tick(output logic [3:0] rs);
    logic [3:0] pin;
    logic r;
    @(negedge clk);
    #2;
    pin = row_n;
    r = reset;
    @(posedge clk);
    m_valid = 1'b0;
    if (r) begin
      m_idx = 2'd0; m_val = 8'h00; m_held = 1'b0;
      h1 = 4'hF; h2 = 4'hF; rflag = 1'b1; m_in_deb = 1'b0;
      rs = 4'hF;
    end else begin
      rs = h2; h2 = h1; h1 = pin;
    end
  endtask

  initial begin : model
    logic [3:0] rs, row;
    int cnt;
    bit go;
    forever begin
      rflag = 1'b0;
      m_in_deb = 1'b0;
      // look for a column showing exactly one pressed row
      go = 1'b0;
      while (!go && !rflag) begin
        for (int d = 0; d < SD; d++) begin
          tick(rs);
          if (rflag) break;
        end
        if (rflag) break;
        if ($countones(~rs) == 1) go = 1'b1;
        else m_idx = m_idx + 2'd1;
      end
      if (rflag) continue;
      // require DB consecutive matching cycles
      row = ~rs; m_in_deb = 1'b1; cnt = 0; go = 1'b0;
      while (1) begin
        tick(rs);
        if (rflag) break;
        if (~rs != row) begin m_idx = m_idx + 2'd1; break; end
        if (cnt == DB - 1) begin
          m_val = {row, 4'b1000 >> m_idx};
          m_valid = 1'b1; m_held = 1'b1; go = 1'b1;
          break;
        end
        cnt++;
      end
      m_in_deb = 1'b0;
      if (!go) continue;
      // held until all rows high for DB consecutive cycles
      go = 1'b0;
      while (!go && !rflag) begin
        tick(rs);
        if (rflag) break;
        if (rs == 4'hF) begin
          cnt = 0;
          while (1) begin
            tick(rs);
            if (rflag || rs != 4'hF) break;
            if (cnt == DB - 1) begin
              m_held = 1'b0; m_idx = m_idx + 2'd1; go = 1'b1;
              break;
            end
            cnt++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] ec;
    if (chk_on) begin
      ec = ~(4'b0001 << m_idx);
      chk("col_n", {28'd0, col_n}, {28'd0, ec});
      chk("keypad_val", {24'd0, keypad_val}, {24'd0, m_val});
      chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
      chk("key_held", {31'd0, key_held}, {31'd0, m_held});
    end
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) pulses++;
  end

  initial begin
    #7 chk_on = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, n;
    bit seen;
    reset = 1'b1;
    wait_cyc(3);
    chk("rst_col", {28'd0, col_n}, 32'hE);
    chk("rst_val", {24'd0, keypad_val}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_held", {31'd0, key_held}, 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    // '5' held 40 cycles
    p0 = pulses;
    keys = 16'h0020;
    wait_cyc(40);
    chk("k5_held", {31'd0, key_held}, 32'h1);
    chk("k5_col", {28'd0, col_n}, 32'hD);
    keys = 16'h0;
    wait_cyc(15);
    chk("k5_released", {31'd0, key_held}, 32'h0);
    chk("k5_pulses", pulses - p0, 1);
    chk("k5_val", {24'd0, keypad_val}, 32'h24);

    // '0' with bounce on press and on release
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      keys = 16'h2000; wait_cyc(1);
      keys = 16'h0;    wait_cyc(1);
    end
    keys = 16'h2000;
    wait_cyc(50);
    keys = 16'h0;    wait_cyc($urandom_range(1, 3));
    keys = 16'h2000; wait_cyc($urandom_range(1, 3));
    keys = 16'h0;
    wait_cyc(20);
    chk("k0_pulses", pulses - p0, 1);
    chk("k0_val", {24'd0, keypad_val}, 32'h84);

    // '1', then '4' on same column, then '3' on another column
    p0 = pulses;
    keys = 16'h0001; wait_cyc(40);
    keys = keys | 16'h0010; wait_cyc(20);
    keys = keys | 16'h0004; wait_cyc(20);
    chk("k1_val", {24'd0, keypad_val}, 32'h18);
    chk("k1_pulses", pulses - p0, 1);
    keys = 16'h0; wait_cyc(20);
    keys = 16'h8000; wait_cyc(40);
    keys = 16'h0; wait_cyc(20);
    chk("kF_pulses", pulses - p0, 2);
    chk("kF_val", {24'd0, keypad_val}, 32'h81);

    // '2' and '8' together: ghost/multi-key, never accepted
    p0 = pulses;
    keys = 16'h0202; wait_cyc(40);
    chk("k28_pulses", pulses - p0, 0);
    chk("k28_held", {31'd0, key_held}, 32'h0);
    keys = 16'h0; wait_cyc(10);

    // 'E' with reset during debounce, then a fresh press
    p0 = pulses;
    keys = 16'h0800;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      wait_cyc(1);
      seen = m_in_deb;
    end
    chk("kE_reached_debounce", {31'd0, seen}, 32'h1);
    wait_cyc(3);
    reset = 1'b1; wait_cyc(1);
    reset = 1'b0;
    chk("kE_rst_col", {28'd0, col_n}, 32'hE);
    chk("kE_rst_val", {24'd0, keypad_val}, 32'h0);
    chk("kE_rst_held", {31'd0, key_held}, 32'h0);
    chk("kE_no_pulse", pulses - p0, 0);
    wait_cyc(40);
    chk("kE_pulses", pulses - p0, 1);
    chk("kE_val", {24'd0, keypad_val}, 32'h41);
    keys = 16'h0; wait_cyc(20);

    // random activity checked by the model
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 2);
      keys = 16'h0;
      for (int k = 0; k < n; k++) keys[$urandom_range(0, 15)] = 1'b1;
      wait_cyc($urandom_range(5, 50));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1; wait_cyc(1); reset = 1'b0;
      end
      keys = 16'h0;
      wait_cyc($urandom_range(3, 30));
    end
    wait_cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
